param_func_gen: RTL and testbench
=================================

PARAM_FUNC_GEN -- requirements
Module: param_func_gen

Interface
REQ-001 Parameter OUT_W, default 8, output sample width in bits; legal range 4..16.
REQ-002 Parameter ACC_W, default 16, phase accumulator width in bits; legal range OUT_W..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  phase advance enable.
REQ-006 sel  input  3  waveform mode select.
REQ-007 ftw  input  ACC_W  frequency tuning word (phase step per clk).
REQ-008 ftw_load  input  1  single-cycle strobe; capture ftw as pending step.
REQ-009 duty  input  OUT_W  square-wave threshold.
REQ-010 out  output  OUT_W  registered sample, offset-binary (midscale = 2^(OUT_W-1)).
REQ-011 wrap  output  1  one-cycle pulse aligned with the first post-wrap sample on out.
REQ-012 ftw_busy  output  1  high while a pending step awaits application.

Function
REQ-013 Accumulator acc SHALL update acc <= acc + ftw_act (mod 2^ACC_W) on every clk with en=1, and hold with en=0.
REQ-014 ftw_load SHALL write ftw into ftw_pend and set pend; a load while pend=1 SHALL overwrite ftw_pend.
REQ-015 With pend=1, ftw_act SHALL take ftw_pend and pend SHALL clear on the cycle acc carries out, or on any cycle with en=0 or ftw_act=0.
REQ-016 Simultaneous ftw_load and apply: the old ftw_pend SHALL be applied, the new ftw SHALL be captured, and pend SHALL remain 1.
REQ-017 Phase p = acc[ACC_W-1 -: OUT_W]; x = p[OUT_W-2:0]; h = p[OUT_W-1].
REQ-018 sel=000 sine: prod = x*(2^(OUT_W-1)-1-x); mag = prod[2*OUT_W-5 : OUT_W-3]; out = h ? {1'b0, ~mag} : {1'b1, mag}.
REQ-019 sel=001 square: out = all ones when p < duty, else 0; duty=0 gives constant 0.
REQ-020 sel=010 triangle: t = {x,1'b0}; out = h ? ~t : t.
REQ-021 sel=011 ramp up, out = p; sel=100 ramp down, out = ~p.
REQ-022 sel=110/111, and sel=101 without the macro: out = midscale.
REQ-023 Two-stage pipeline: stage 1 registers p, sel, duty and carry; stage 2 registers out and wrap; out reflects acc and sel exactly 2 clk after sampling, in every mode.
REQ-024 wrap SHALL pulse for one clk, 2 clk after the accumulator carry.
REQ-025 ftw_busy = pend, registered.

Reset
REQ-026 rst=1 SHALL immediately clear acc, ftw_act, ftw_pend, pend, all pipeline registers, out=0, wrap=0 and ftw_busy=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any pending step; after release, out is 0 until the pipeline refills (2 clk).

Configuration
REQ-028 Macro PARAM_FUNC_GEN_NOISE_EN defined: 16-bit Galois LFSR with x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advancing each clk with en=1; sel=101 out = lfsr[OUT_W-1:0], with the same 2-clk alignment.
REQ-029 Macro undefined: no LFSR logic synthesised; sel=101 gives midscale.

Verification (OUT_W=8, ACC_W=16)
REQ-030 Reset, en=1, ftw_load with ftw=16'h0100, sel=011 -> ftw_busy clears next clk; out counts 0,1,2,...,255,0; wrap pulses every 256 clk.
REQ-031 ftw=16'h0100, sel=001, duty=8'h40 -> out=8'hFF for 64 clk, then 8'h00 for 192 clk, repeating.
REQ-032 Sine with p held via en=0 -> p=8'h00 gives 8'h80, 8'h40 gives 8'hFE, 8'h80 gives 8'h7F, 8'hC0 gives 8'h01.
REQ-033 Running at step 16'h0100, ftw_load 16'h0200 at acc=16'h3000 -> ftw_busy=1, step stays 16'h0100 until carry, then 16'h0200 and ftw_busy=0.
REQ-034 rst asserted between clk edges mid-run -> out=0, wrap=0, ftw_busy=0 immediately; pending step discarded.
REQ-035 With PARAM_FUNC_GEN_NOISE_EN, sel=101 -> first post-reset sample 8'hE1, following the LFSR sequence; without macro -> 8'h80.

Source files
------------

// File: rtl/param_func_gen.sv
// Phase-accumulator function generator: sine, square, triangle, ramp up/down, midscale.
// Define PARAM_FUNC_GEN_NOISE_EN to add a 16-bit LFSR noise source on sel=101.
module param_func_gen #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [ACC_W-1:0] ftw,
  input  logic             ftw_load,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] out,
  output logic             wrap,
  output logic             ftw_busy
);

  localparam int unsigned X_W     = OUT_W - 1;
  localparam int unsigned PROD_W  = 2 * X_W;
  localparam int unsigned MAG_LSB = OUT_W - 3;

  localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {X_W{1'b0}}};
  localparam logic [X_W-1:0]   X_MAX    = '1;

  localparam logic [2:0] SEL_SINE   = 3'b000;
  localparam logic [2:0] SEL_SQUARE = 3'b001;
  localparam logic [2:0] SEL_TRI    = 3'b010;
  localparam logic [2:0] SEL_RAMPUP = 3'b011;
  localparam logic [2:0] SEL_RAMPDN = 3'b100;
`ifdef PARAM_FUNC_GEN_NOISE_EN
  localparam logic [2:0] SEL_NOISE  = 3'b101;
`endif

  // Phase accumulator and step-update state
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0] ftw_pend_q, ftw_pend_d;
  logic             pend_q, pend_d;
  logic [ACC_W:0]   sum_c;
  logic             apply_c;

  // Stage 1 registers
  logic [OUT_W-1:0] p1_q;
  logic [2:0]       sel1_q;
  logic [OUT_W-1:0] duty1_q;
  logic             carry1_q;
  logic             v1_q;

  // Stage 2 (output) registers
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  // Waveform shaping
  logic [X_W-1:0]    x_c;
  logic              h_c;
  logic [PROD_W-1:0] prod_c;
  logic [X_W-1:0]    mag_c;
  logic [OUT_W-1:0]  tri_c;
  logic [OUT_W-1:0]  wave_c;

`ifdef PARAM_FUNC_GEN_NOISE_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [OUT_W-1:0] noise1_q;
`endif

  // A pending step is applied at the wrap so the phase never jumps mid-cycle,
  // or right away when the accumulator is idle (stopped or zero step).
  always_comb begin
    sum_c      = {1'b0, acc_q} + {1'b0, ftw_act_q};
    apply_c    = pend_q & ((en & sum_c[ACC_W]) | ~en | (ftw_act_q == '0));
    acc_d      = acc_q;
    carry_d    = 1'b0;
    ftw_act_d  = ftw_act_q;
    ftw_pend_d = ftw_pend_q;
    pend_d     = pend_q;
    if (en) begin
      acc_d   = sum_c[ACC_W-1:0];
      carry_d = sum_c[ACC_W];
    end
    if (apply_c) begin
      ftw_act_d = ftw_pend_q;
      pend_d    = 1'b0;
    end
    if (ftw_load) begin
      ftw_pend_d = ftw;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      carry_q    <= 1'b0;
      ftw_act_q  <= '0;
      ftw_pend_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      ftw_act_q  <= ftw_act_d;
      ftw_pend_q <= ftw_pend_d;
      pend_q     <= pend_d;
    end
  end

`ifdef PARAM_FUNC_GEN_NOISE_EN
  // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= 16'hACE1;
      noise1_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      noise1_q <= lfsr_q[OUT_W-1:0];
    end
  end
`endif

  // v1_q keeps stage 2 at zero until stage 1 holds a real sample after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q     <= '0;
      sel1_q   <= '0;
      duty1_q  <= '0;
      carry1_q <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      p1_q     <= acc_q[ACC_W-1 -: OUT_W];
      sel1_q   <= sel;
      duty1_q  <= duty;
      carry1_q <= carry_q;
      v1_q     <= 1'b1;
    end
  end

  // Parabolic half-wave approximation of sine; h selects the polarity
  always_comb begin
    x_c    = p1_q[X_W-1:0];
    h_c    = p1_q[OUT_W-1];
    prod_c = PROD_W'(x_c) * PROD_W'(X_MAX - x_c);
    mag_c  = X_W'(prod_c >> MAG_LSB);
    tri_c  = {x_c, 1'b0};
    wave_c = MIDSCALE;
    case (sel1_q)
      SEL_SINE:   wave_c = h_c ? {1'b0, ~mag_c} : {1'b1, mag_c};
      SEL_SQUARE: wave_c = (p1_q < duty1_q) ? '1 : '0;
      SEL_TRI:    wave_c = h_c ? ~tri_c : tri_c;
      SEL_RAMPUP: wave_c = p1_q;
      SEL_RAMPDN: wave_c = ~p1_q;
`ifdef PARAM_FUNC_GEN_NOISE_EN
      SEL_NOISE:  wave_c = noise1_q;
`endif
      default:    wave_c = MIDSCALE;
    endcase
    out_d  = v1_q ? wave_c : '0;
    wrap_d = v1_q & carry1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out      = out_q;
  assign wrap     = wrap_q;
  assign ftw_busy = pend_q;

endmodule

// File: tb/tb_param_func_gen.sv
// Directed self-checking bench for param_func_gen at OUT_W=8, ACC_W=16.
module tb_param_func_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  sel;
  logic [15:0] ftw;
  logic        ftw_load;
  logic [7:0]  duty;
  logic [7:0]  out;
  logic        wrap;
  logic        ftw_busy;

  int n_checks;
  int n_fail;

  param_func_gen #(.OUT_W(8), .ACC_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sel      (sel),
    .ftw      (ftw),
    .ftw_load (ftw_load),
    .duty     (duty),
    .out      (out),
    .wrap     (wrap),
    .ftw_busy (ftw_busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset then release on a falling edge; the next rising edge is E0.
  task automatic do_reset;
    rst      = 1'b1;
    en       = 1'b0;
    sel      = 3'b000;
    ftw      = '0;
    ftw_load = 1'b0;
    duty     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    n_checks++;
    if (ftw_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ftw_busy); end
    do_reset();
  endtask

  // Output at sample k reflects the accumulator after edge k-2 (0,0,0,0x100,...).
  task automatic test_ramp;
    int ph;
    logic [7:0] exp_out;
    logic exp_wrap, exp_busy;
    do_reset();
    sel = 3'b011; en = 1'b1; ftw = 16'h0100; ftw_load = 1'b1;
    for (int k = 0; k <= 520; k++) begin
      tick();
      ftw_load = 1'b0;
      ph       = (k < 3) ? 0 : (k - 3);
      exp_out  = (k == 0) ? 8'h00 : 8'(ph);
      exp_wrap = (k >= 259) && (((k - 259) % 256) == 0);
      exp_busy = (k == 0);
      n_checks++;
      if (out !== exp_out) begin n_fail++; $display("FAIL ramp_out k=%0d: got %h expected %h", k, out, exp_out); end
      n_checks++;
      if (wrap !== exp_wrap) begin n_fail++; $display("FAIL ramp_wrap k=%0d: got %b expected %b", k, wrap, exp_wrap); end
      n_checks++;
      if (ftw_busy !== exp_busy) begin n_fail++; $display("FAIL ramp_busy k=%0d: got %b expected %b", k, ftw_busy, exp_busy); end
    end
  endtask

  task automatic test_square;
    int ph;
    logic [7:0] exp_out;
    do_reset();
    sel = 3'b001; duty = 8'h40; en = 1'b1; ftw = 16'h0100; ftw_load = 1'b1;
    for (int k = 0; k <= 600; k++) begin
      tick();
      ftw_load = 1'b0;
      ph       = (k < 3) ? 0 : (k - 3);
      exp_out  = (k == 0) ? 8'h00 : ((8'(ph) < 8'h40) ? 8'hFF : 8'h00);
      n_checks++;
      if (out !== exp_out) begin n_fail++; $display("FAIL square_out k=%0d: got %h expected %h", k, out, exp_out); end
    end
  endtask

  // Phase held with en=0; every mode is checked at p = 00, 40, 80, C0.
  task automatic test_shapes_held;
    logic [2:0] modes [5];
    logic [7:0] exp_tab [4][5];
    modes = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
    exp_tab[0] = '{8'h80, 8'h00, 8'hFF, 8'h80, 8'h80};
    exp_tab[1] = '{8'hFE, 8'h80, 8'hBF, 8'h80, 8'h80};
    exp_tab[2] = '{8'h7F, 8'hFF, 8'h7F, 8'h80, 8'h80};
    exp_tab[3] = '{8'h01, 8'h7F, 8'h3F, 8'h80, 8'h80};
    do_reset();
    en = 1'b0; ftw = 16'h4000; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      for (int m = 0; m < 5; m++) begin
        sel = modes[m];
        repeat (3) tick();
        n_checks++;
        if (out !== exp_tab[p][m]) begin
          n_fail++;
          $display("FAIL shape p=%0d sel=%b: got %h expected %h", p, modes[m], out, exp_tab[p][m]);
        end
      end
      en = 1'b1;
      tick();
      en = 1'b0;
    end
  endtask

  // New step loaded at acc=0x3000 stays pending until the carry at edge 257.
  task automatic test_ftw_update;
    int ph;
    logic [7:0] exp_out;
    logic exp_wrap, exp_busy;
    do_reset();
    sel = 3'b011; en = 1'b1; ftw = 16'h0100; ftw_load = 1'b1;
    for (int k = 0; k <= 400; k++) begin
      tick();
      if (k < 3) ph = 0;
      else if (k <= 258) ph = k - 3;
      else ph = 2 * (k - 259);
      exp_out  = (k == 0) ? 8'h00 : 8'(ph);
      exp_wrap = (k == 259) || (k == 387);
      exp_busy = (k == 0) || ((k >= 50) && (k <= 256));
      n_checks++;
      if (out !== exp_out) begin n_fail++; $display("FAIL upd_out k=%0d: got %h expected %h", k, out, exp_out); end
      n_checks++;
      if (wrap !== exp_wrap) begin n_fail++; $display("FAIL upd_wrap k=%0d: got %b expected %b", k, wrap, exp_wrap); end
      n_checks++;
      if (ftw_busy !== exp_busy) begin n_fail++; $display("FAIL upd_busy k=%0d: got %b expected %b", k, ftw_busy, exp_busy); end
      ftw_load = (k == 49);
      if (k == 49) ftw = 16'h0200;
    end
  endtask

  // Load lands on the same edge an older pending step is applied.
  task automatic test_back_to_back;
    do_reset();
    sel = 3'b011; en = 1'b0; ftw = 16'h0500; ftw_load = 1'b1;
    tick();
    n_checks++;
    if (ftw_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy0: got %b expected 1", ftw_busy); end
    ftw = 16'h0700;
    tick();
    ftw_load = 1'b0;
    n_checks++;
    if (ftw_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1: got %b expected 1", ftw_busy); end
    tick();
    n_checks++;
    if (ftw_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy2: got %b expected 0", ftw_busy); end
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (out !== 8'h07) begin n_fail++; $display("FAIL b2b_step: got %h expected 07", out); end
  endtask

  task automatic test_reset_midrun;
    do_reset();
    sel = 3'b011; en = 1'b1; ftw = 16'h0100; ftw_load = 1'b1;
    for (int k = 0; k <= 39; k++) begin
      tick();
      ftw_load = (k == 29);
      if (k == 29) ftw = 16'h0300;
    end
    n_checks++;
    if (out !== 8'h24) begin n_fail++; $display("FAIL mid_out_pre: got %h expected 24", out); end
    n_checks++;
    if (ftw_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b expected 1", ftw_busy); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out !== 8'h00) begin n_fail++; $display("FAIL mid_out_rst: got %h expected 00", out); end
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("FAIL mid_wrap_rst: got %b expected 0", wrap); end
    n_checks++;
    if (ftw_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_rst: got %b expected 0", ftw_busy); end
    @(negedge clk);
    rst = 1'b0; ftw_load = 1'b0; sel = 3'b001; duty = 8'h40;
    tick();
    n_checks++;
    if (out !== 8'h00) begin n_fail++; $display("FAIL mid_refill0: got %h expected 00", out); end
    tick();
    n_checks++;
    if (out !== 8'hFF) begin n_fail++; $display("FAIL mid_refill1: got %h expected FF", out); end
    sel = 3'b011;
    repeat (30) tick();
    n_checks++;
    if (out !== 8'h00) begin n_fail++; $display("FAIL mid_discard_out: got %h expected 00", out); end
    n_checks++;
    if (ftw_busy !== 1'b0) begin n_fail++; $display("FAIL mid_discard_busy: got %b expected 0", ftw_busy); end
  endtask

  task automatic test_noise;
    logic [7:0] exp_seq [3];
`ifdef PARAM_FUNC_GEN_NOISE_EN
    exp_seq = '{8'hE1, 8'h70, 8'h38};
`else
    exp_seq = '{8'h80, 8'h80, 8'h80};
`endif
    do_reset();
    sel = 3'b101; en = 1'b1;
    tick();
    n_checks++;
    if (out !== 8'h00) begin n_fail++; $display("FAIL noise_s0: got %h expected 00", out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out !== exp_seq[i]) begin n_fail++; $display("FAIL noise_s%0d: got %h expected %h", i + 1, out, exp_seq[i]); end
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b0;
    en       = 1'b0;
    sel      = 3'b000;
    ftw      = '0;
    ftw_load = 1'b0;
    duty     = '0;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ramp();
    test_square();
    test_shapes_held();
    test_ftw_update();
    test_back_to_back();
    test_reset_midrun();
    test_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
